// File: rtl/comparador_alarme.sv
// Multi-channel alarm comparator: each channel rings on the rising edge of
// hora_atual == valor, with snooze, acknowledge and auto-off after RING_TICKS.
module comparador_alarme #(
  parameter int unsigned WIDTH        = 12,
  parameter int unsigned N_CH         = 4,
  parameter int unsigned RING_TICKS   = 60,
  parameter int unsigned SNOOZE_TICKS = 5,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] hora_atual,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_valor,
  input  logic             wr_hab,
  input  logic             ack,
  input  logic             soneca,
  output logic [N_CH-1:0]  igual,
  output logic             alarme,
  output logic [CH_W-1:0]  canal_ativo
);

  localparam int unsigned RING_W = $clog2(RING_TICKS + 1);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_TICKS + 1);

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TICKS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_TICKS);
  localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

  localparam logic [1:0] StDesligado = 2'd0;
  localparam logic [1:0] StArmado    = 2'd1;
  localparam logic [1:0] StTocando   = 2'd2;
  localparam logic [1:0] StSoneca    = 2'd3;

  logic [WIDTH-1:0]  valor_q [N_CH];
  logic [WIDTH-1:0]  valor_d [N_CH];
  logic [1:0]        state_q [N_CH];
  logic [1:0]        state_d [N_CH];
  logic [RING_W-1:0] ring_q  [N_CH];
  logic [RING_W-1:0] ring_d  [N_CH];
  logic [SNZ_W-1:0]  snz_q   [N_CH];
  logic [SNZ_W-1:0]  snz_d   [N_CH];
  logic [N_CH-1:0]   igual_q, igual_d;
  logic [N_CH-1:0]   eq;
  logic              wr_hit;

  assign wr_hit = wr_en && (32'(wr_ch) < N_CH);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      eq[i] = (hora_atual == valor_q[i]);
    end
  end

  always_comb begin
    igual_d = eq;
    for (int i = 0; i < N_CH; i++) begin
      valor_d[i] = valor_q[i];
      state_d[i] = state_q[i];
      ring_d[i]  = ring_q[i];
      snz_d[i]   = snz_q[i];
      if (wr_hit && (wr_ch == CH_W'(i))) begin
        // Seed igual from the new value so a write matching the current time stays quiet.
        valor_d[i] = wr_valor;
        state_d[i] = wr_hab ? StArmado : StDesligado;
        ring_d[i]  = '0;
        snz_d[i]   = '0;
        igual_d[i] = (hora_atual == wr_valor);
      end else begin
        unique case (state_q[i])
          StArmado: begin
            if (eq[i] && !igual_q[i]) begin
              state_d[i] = StTocando;
              ring_d[i]  = '0;
            end
          end
          StTocando: begin
            if (ack) begin
              state_d[i] = StArmado;
              ring_d[i]  = '0;
            end else if (soneca) begin
              state_d[i] = StSoneca;
              snz_d[i]   = SNZ_LOAD;
            end else if (tick) begin
              if (ring_q[i] == RING_LAST) begin
                state_d[i] = StArmado;
                ring_d[i]  = '0;
              end else begin
                ring_d[i] = ring_q[i] + 1'b1;
              end
            end
          end
          StSoneca: begin
            if (ack) begin
              state_d[i] = StArmado;
              snz_d[i]   = '0;
            end else if (tick) begin
              if (snz_q[i] == SNZ_ONE) begin
                state_d[i] = StTocando;
                ring_d[i]  = '0;
                snz_d[i]   = '0;
              end else begin
                snz_d[i] = snz_q[i] - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      igual_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        valor_q[i] <= '0;
        state_q[i] <= StDesligado;
        ring_q[i]  <= '0;
        snz_q[i]   <= '0;
      end
    end else begin
      igual_q <= igual_d;
      for (int i = 0; i < N_CH; i++) begin
        valor_q[i] <= valor_d[i];
        state_q[i] <= state_d[i];
        ring_q[i]  <= ring_d[i];
        snz_q[i]   <= snz_d[i];
      end
    end
  end

  // Downward scan leaves the lowest ringing index in canal_ativo.
  always_comb begin
    alarme      = 1'b0;
    canal_ativo = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (state_q[i] == StTocando) begin
        alarme      = 1'b1;
        canal_ativo = CH_W'(i);
      end
    end
  end

  assign igual = igual_q;

endmodule

// File: tb/tb_comparador_alarme.sv
// Scoreboard bench for comparador_alarme: a per-channel behavioural model
// predicts {alarme, canal_ativo, igual} after every clock edge.
module tb_comparador_alarme;

  localparam int W     = 12;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
  localparam int RING  = 60;
  localparam int SNZ   = 5;

  localparam int MOff  = 0;
  localparam int MArm  = 1;
  localparam int MRing = 2;
  localparam int MSnz  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           tick = 1'b0;
  logic [W-1:0]   hora_atual = '0;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [W-1:0]   wr_valor = '0;
  logic           wr_hab = 1'b0;
  logic           ack = 1'b0;
  logic           soneca = 1'b0;
  logic [NCH-1:0] igual;
  logic           alarme;
  logic [CHW-1:0] canal_ativo;

  comparador_alarme #(
    .WIDTH       (W),
    .N_CH        (NCH),
    .RING_TICKS  (RING),
    .SNOOZE_TICKS(SNZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .hora_atual (hora_atual),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_valor   (wr_valor),
    .wr_hab     (wr_hab),
    .ack        (ack),
    .soneca     (soneca),
    .igual      (igual),
    .alarme     (alarme),
    .canal_ativo(canal_ativo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: alarm time, mode, ticks rung so far, ticks of snooze left, last equality.
  int m_val  [NCH];
  int m_mode [NCH];
  int m_rung [NCH];
  int m_left [NCH];
  bit m_ig   [NCH];

  logic [NCH+CHW:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_val[c] = 0; m_mode[c] = MOff; m_rung[c] = 0; m_left[c] = 0; m_ig[c] = 0;
    end
  endtask

  function automatic logic [NCH+CHW:0] model_outputs();
    logic           al;
    logic [CHW-1:0] ca;
    logic [NCH-1:0] ig;
    al = 1'b0; ca = '0; ig = '0;
    for (int c = 0; c < NCH; c++) begin
      ig[c] = m_ig[c];
      if (m_mode[c] == MRing && !al) begin
        al = 1'b1;
        ca = CHW'(c);
      end
    end
    return {al, ca, ig};
  endfunction

  task automatic model_step(input bit rst, input bit t, input int h, input bit we,
                            input int ch, input int v, input bit hab, input bit a, input bit s);
    bit eq;
    bit fire;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      eq   = (h == m_val[c]);
      fire = eq && !m_ig[c];
      m_ig[c] = eq;
      if (we && ch == c) begin
        m_val[c]  = v;
        m_mode[c] = hab ? MArm : MOff;
        m_rung[c] = 0;
        m_left[c] = 0;
        m_ig[c]   = (h == v);
      end else if ((m_mode[c] == MRing || m_mode[c] == MSnz) && a) begin
        m_mode[c] = MArm;
      end else if (m_mode[c] == MRing && s) begin
        m_mode[c] = MSnz;
        m_left[c] = SNZ;
      end else if (m_mode[c] == MArm && fire) begin
        m_mode[c] = MRing;
        m_rung[c] = 0;
      end else if (m_mode[c] == MRing && t) begin
        m_rung[c]++;
        if (m_rung[c] >= RING) m_mode[c] = MArm;
      end else if (m_mode[c] == MSnz && t) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_mode[c] = MRing;
          m_rung[c] = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the outcome of the next rise.
  task automatic cycle(input bit rst, input bit t, input int h, input bit we, input int ch,
                       input int v, input bit hab, input bit a, input bit s);
    @(negedge clk);
    rst_n      = rst;
    tick       = t;
    hora_atual = W'(h);
    wr_en      = we;
    wr_ch      = CHW'(ch);
    wr_valor   = W'(v);
    wr_hab     = hab;
    ack        = a;
    soneca     = s;
    model_step(rst, t, h, we, ch, v, hab, a, s);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n, input int h);
    for (int k = 0; k < n; k++) cycle(1, 0, h, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int h, input int ch, input int v, input bit hab);
    cycle(1, 0, h, 1, ch, v, hab, 0, 0);
  endtask

  // Monitor: compares every DUT output set against the queued prediction.
  initial begin
    logic [NCH+CHW:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{alarme,canal,igual}", int'({alarme, canal_ativo, igual}), int'(e));
      end
    end
  end

  initial begin
    int h;
    int r;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_alarme", int'(alarme), 0);
    check("reset_canal", int'(canal_ativo), 0);
    check("reset_igual", int'(igual), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Rising-edge trigger on ch1, then ack while equality holds.
    wr(12'h72F, 1, 12'h730, 1);
    idle(2, 12'h72F);
    idle(3, 12'h730);
    cycle(1, 0, 12'h730, 0, 0, 0, 0, 1, 0);
    idle(5, 12'h730);
    // Re-trigger after time leaves and returns.
    idle(2, 12'h731);
    idle(2, 12'h730);
    cycle(1, 0, 12'h730, 0, 0, 0, 0, 1, 0);

    // Snooze on ch0, 5 tick pulses back to ringing, then full auto-off.
    wr(12'h1FF, 0, 12'h200, 1);
    idle(2, 12'h200);
    cycle(1, 0, 12'h200, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < SNZ; k++) begin
      cycle(1, 1, 12'h200, 0, 0, 0, 0, 0, 0);
      idle(1, 12'h200);
    end
    for (int k = 0; k < RING; k++) begin
      cycle(1, 1, 12'h200, 0, 0, 0, 0, 0, 0);
      if (k % 7 == 0) idle(1, 12'h200);
    end
    idle(3, 12'h200);

    // Two channels ringing together; lowest index reported; ack clears both.
    wr(12'h0FF, 0, 12'h100, 1);
    wr(12'h0FF, 2, 12'h100, 1);
    idle(3, 12'h100);
    cycle(1, 0, 12'h100, 0, 0, 0, 0, 1, 0);
    idle(2, 12'h100);

    // Write equal to current time does not fire; disable during ring; ack+soneca together.
    idle(1, 12'h300);
    wr(12'h300, 3, 12'h300, 1);
    idle(3, 12'h300);
    wr(12'h30F, 1, 12'h310, 1);
    idle(2, 12'h310);
    wr(12'h310, 1, 12'h310, 0);
    idle(2, 12'h310);
    wr(12'h31F, 1, 12'h320, 1);
    idle(2, 12'h320);
    cycle(1, 1, 12'h320, 0, 0, 0, 0, 1, 1);
    idle(2, 12'h320);

    // Asynchronous reset mid-ring.
    wr(12'h3FF, 2, 12'h400, 1);
    idle(3, 12'h400);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_alarme", int'(alarme), 0);
    check("async_reset_igual", int'(igual), 0);
    check("async_reset_canal", int'(canal_ativo), 0);
    model_reset();
    cycle(0, 0, 12'h400, 0, 0, 0, 0, 0, 0);
    idle(4, 12'h400);
    idle(2, 0);
    idle(2, 12'h730);

    // Randomised traffic.
    h = 12'h100;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: h = 12'h100;
        1: h = 12'h200;
        2: h = 12'h730;
        3: h = int'($urandom_range(0, 4095));
        default: ;
      endcase
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        case ($urandom_range(0, 2))
          0: wr(h, int'($urandom_range(0, 3)), 12'h100, $urandom_range(0, 3) != 0);
          1: wr(h, int'($urandom_range(0, 3)), 12'h200, $urandom_range(0, 3) != 0);
          default: wr(h, int'($urandom_range(0, 3)), 12'h730, $urandom_range(0, 3) != 0);
        endcase
      end else begin
        cycle(1, $urandom_range(0, 1) == 1, h, 0, 0, 0, 0,
              $urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0);
      end
    end

    idle(2, h);
    @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comparador_alarme.md
COMPARADOR_ALARME -- requirements
Module: comparador_alarme

Interface
REQ-001 Parameter WIDTH, 12, width of time word and stored alarm values.
REQ-002 Parameter N_CH, 4, number of independent alarm channels (1..16).
REQ-003 Parameter RING_TICKS, 60, ticks an alarm rings before auto-off (>=1).
REQ-004 Parameter SNOOZE_TICKS, 5, ticks spent in snooze before re-ring (>=1).
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port tick  in  1  one-cycle time-base pulse that advances ring/snooze counters.
REQ-008 Port hora_atual  in  WIDTH  current time word.
REQ-009 Port wr_en  in  1  write strobe for channel configuration.
REQ-010 Port wr_ch  in  CH_W = max(1, clog2(N_CH))  channel index for write; index >= N_CH ignored.
REQ-011 Port wr_valor  in  WIDTH  alarm time to store.
REQ-012 Port wr_hab  in  1  channel enable to store.
REQ-013 Port ack  in  1  stop all ringing/snoozing channels.
REQ-014 Port soneca  in  1  snooze all ringing channels.
REQ-015 Port igual  out  N_CH  registered per-channel equality hora_atual == valor[i].
REQ-016 Port alarme  out  1  high while any channel is TOCANDO.
REQ-017 Port canal_ativo  out  CH_W  lowest channel index in TOCANDO; 0 when none.

Function
REQ-018 Each channel SHALL hold valor[i] (WIDTH), an FSM {DESLIGADO, ARMADO, TOCANDO, SONECA}, a ring counter and a snooze counter.
REQ-019 eq[i] = (hora_atual == valor[i]), full WIDTH unsigned compare; igual[i] SHALL register eq[i] each cycle (1-cycle latency).
REQ-020 Trigger[i] = eq[i] & ~igual[i]; a channel fires only on the rising edge of equality, never repeatedly while equality holds.
REQ-021 ARMADO -> TOCANDO on trigger; ring counter cleared on entry; alarme SHALL assert the cycle after hora_atual first equals valor.
REQ-022 TOCANDO: ring counter increments on tick; at RING_TICKS ticks -> ARMADO (auto-off).
REQ-023 TOCANDO + soneca -> SONECA, snooze counter loaded with SNOOZE_TICKS.
REQ-024 SONECA: snooze counter decrements on tick; on the tick that reaches 0 -> TOCANDO with ring counter cleared.
REQ-025 ack in TOCANDO or SONECA -> ARMADO; ack/soneca in DESLIGADO or ARMADO have no effect.
REQ-026 DESLIGADO ignores trigger; igual[i] still updates.
REQ-027 Write to channel c: valor[c] <= wr_valor; state <= ARMADO if wr_hab else DESLIGADO; counters cleared; igual[c] <= (hora_atual == wr_valor), so a write equal to current time does not fire.
REQ-028 Priority per channel, same cycle: write > ack > soneca > trigger/tick events.
REQ-029 tick and ack same cycle: ack wins, counter not advanced.
REQ-030 Channels SHALL be independent; several may ring at once; alarme = OR of TOCANDO; canal_ativo from registered state (no extra latency beyond state).
REQ-031 hora_atual jumping away and back SHALL re-trigger (new rising edge).

Reset
REQ-032 rst_n low SHALL immediately force: all states DESLIGADO, valor 0, counters 0, igual 0, alarme 0, canal_ativo 0.
REQ-033 Reset mid-ring or mid-snooze SHALL abort with the same values; after release no channel fires until written with wr_hab=1.

Verification
REQ-034 Write ch1 valor=12'h0730 hab=1, step hora_atual 12'h072F -> 12'h0730 -> alarme=1 and canal_ativo=1 one cycle later; igual[1]=1.
REQ-035 Ringing ch1, hold hora_atual=12'h0730, pulse ack -> alarme=0 next cycle and stays 0 while hora_atual unchanged.
REQ-036 Ringing ch0, soneca, then SNOOZE_TICKS=5 tick pulses -> alarme 0 for ticks 1-4, 1 after 5th; then RING_TICKS ticks without ack -> alarme=0.
REQ-037 ch0 and ch2 both valor=12'h0100, hab=1; hora_atual=12'h0100 -> alarme=1, canal_ativo=0; ack -> both ARMADO.
REQ-038 Write ch3 valor equal to current hora_atual -> no ring; write hab=0 during ring -> alarme=0 next cycle; same-cycle ack+soneca -> ARMADO.
REQ-039 Assert rst_n low asynchronously during TOCANDO -> alarme=0 without clock edge; all igual=0.
